// File: rtl/i2c_pkg.sv
// Shared encodings and slot timing for the I2C primary controller.
// Each bus slot is four CLK phases; all phase positions live here.
package i2c_pkg;

   localparam int BYTE_W = 8;
   localparam int PH_W   = 2;

   localparam logic [PH_W-1:0] SAMPLE_PHASE    = 2'd2;
   localparam logic [PH_W-1:0] SCL_RISE_PHASE  = 2'd2;
   localparam logic [PH_W-1:0] STOP_SCL_PHASE  = 2'd1;
   localparam logic [PH_W-1:0] START_SDA_PHASE = 2'd2;
   localparam logic [PH_W-1:0] STOP_SDA_PHASE  = 2'd3;

   typedef enum logic [8:0] {
      ST_IDLE     = 9'b0_0000_0001,
      ST_START    = 9'b0_0000_0010,
      ST_ADDR     = 9'b0_0000_0100,
      ST_ADDR_ACK = 9'b0_0000_1000,
      ST_DATA_HI  = 9'b0_0001_0000,
      ST_ACK_HI   = 9'b0_0010_0000,
      ST_DATA_LO  = 9'b0_0100_0000,
      ST_ACK_LO   = 9'b0_1000_0000,
      ST_STOP     = 9'b1_0000_0000
   } state_e;

   typedef enum logic [1:0] {
      SCL_IDLE,
      SCL_START,
      SCL_BIT,
      SCL_STOP
   } scl_mode_e;

endpackage

// File: rtl/i2c_scl_gen.sv
// Slot phase counter and SCL waveform; the counter free-runs while busy so
// every state entry (always at a slot boundary) sees phase 0.
module i2c_scl_gen
   import i2c_pkg::*;
#(
   parameter int PHASES = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            run_i,
   input  scl_mode_e       mode_i,
   output logic [PH_W-1:0] phase_o,
   output logic            last_o,
   output logic            sample_o,
   output logic            scl_o
);

   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

   logic [PH_W-1:0] phase_q, phase_d;

   always_comb begin
      phase_d = '0;
      if (run_i && phase_q != LAST_PHASE) phase_d = phase_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) phase_q <= '0;
      else        phase_q <= phase_d;
   end

   always_comb begin
      scl_o = 1'b1;
      unique case (mode_i)
         SCL_IDLE, SCL_START: scl_o = 1'b1;
         SCL_BIT:             scl_o = (phase_q >= SCL_RISE_PHASE);
         SCL_STOP:            scl_o = (phase_q >= STOP_SCL_PHASE);
         default:             scl_o = 1'b1;
      endcase
   end

   assign phase_o  = phase_q;
   assign last_o   = run_i && (phase_q == LAST_PHASE);
   assign sample_o = run_i && (phase_q == SAMPLE_PHASE);

endmodule

// File: rtl/i2c_primary_ctrl.sv
// I2C primary: one 16-bit word read or write per transaction, with address
// and data-high ACK checking, NACK reporting and a DONE pulse at the end.
module i2c_primary_ctrl
   import i2c_pkg::*;
#(
   parameter int PHASES = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START_STB,
   input  logic        RNW,
   input  logic [6:0]  I2C_ADDR,
   input  logic [15:0] WR_DATA,
   output logic [15:0] RD_DATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        NACK,
   output logic        SCL,
   output logic        SDA_OUT,
   output logic        SDA_OE,
   input  logic        SDA_IN
);

   state_e            state_q;
   logic              rnw_q;
   logic [6:0]        addr_q;
   logic [15:0]       wr_q;
   logic [15:0]       sr_q;
   logic [15:0]       rd_q;
   logic [2:0]        bit_q;
   logic              ack_q;
   logic              nack_q;
   logic              done_q;

   logic              busy;
   logic [PH_W-1:0]   phase;
   logic              last;
   logic              sample;
   scl_mode_e         mode;
   logic [BYTE_W-1:0] addr_byte;
   logic              sda_out, sda_oe;

   assign busy      = (state_q != ST_IDLE);
   assign addr_byte = {addr_q, rnw_q};

   always_comb begin
      mode = SCL_BIT;
      if      (state_q == ST_IDLE)  mode = SCL_IDLE;
      else if (state_q == ST_START) mode = SCL_START;
      else if (state_q == ST_STOP)  mode = SCL_STOP;
   end

   i2c_scl_gen #(.PHASES(PHASES)) u_scl (
      .CLK      (CLK),
      .RESET    (RESET),
      .run_i    (busy),
      .mode_i   (mode),
      .phase_o  (phase),
      .last_o   (last),
      .sample_o (sample),
      .scl_o    (SCL)
   );

   // ack_q holds the phase-2 sample of every slot; only ACK slots consume it.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         wr_q    <= '0;
         sr_q    <= '0;
         rd_q    <= '0;
         bit_q   <= '0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (sample) ack_q <= ~SDA_IN;
         if (sample && (state_q == ST_DATA_HI || state_q == ST_DATA_LO))
            sr_q <= {sr_q[14:0], SDA_IN};
         unique case (state_q)
            ST_IDLE: if (START_STB) begin
               rnw_q   <= RNW;
               addr_q  <= I2C_ADDR;
               wr_q    <= WR_DATA;
               nack_q  <= 1'b0;
               bit_q   <= '0;
               state_q <= ST_START;
            end
            ST_START: if (last) state_q <= ST_ADDR;
            ST_ADDR: if (last) begin
               bit_q <= bit_q + 3'd1;
               if (bit_q == 3'd7) state_q <= ST_ADDR_ACK;
            end
            ST_ADDR_ACK: if (last) begin
               nack_q  <= ~ack_q;
               state_q <= ack_q ? ST_DATA_HI : ST_STOP;
            end
            ST_DATA_HI: if (last) begin
               bit_q <= bit_q + 3'd1;
               if (bit_q == 3'd7) state_q <= ST_ACK_HI;
            end
            ST_ACK_HI: if (last) begin
               if (!rnw_q && !ack_q) begin
                  nack_q  <= 1'b1;
                  state_q <= ST_STOP;
               end else begin
                  state_q <= ST_DATA_LO;
               end
            end
            ST_DATA_LO: if (last) begin
               bit_q <= bit_q + 3'd1;
               if (bit_q == 3'd7) state_q <= ST_ACK_LO;
            end
            ST_ACK_LO: if (last) begin
               if (rnw_q) rd_q <= sr_q;
               state_q <= ST_STOP;
            end
            ST_STOP: if (last) begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Bit slots index MSB first: ~bit_q == 7 - bit_q.
   always_comb begin
      sda_oe  = 1'b1;
      sda_out = 1'b1;
      unique case (state_q)
         ST_IDLE, ST_ADDR_ACK: sda_oe = 1'b0;
         ST_START:   sda_out = (phase < START_SDA_PHASE);
         ST_ADDR:    sda_out = addr_byte[~bit_q];
         ST_DATA_HI: if (rnw_q) sda_oe = 1'b0; else sda_out = wr_q[{1'b1, ~bit_q}];
         ST_ACK_HI:  if (rnw_q) sda_out = 1'b0; else sda_oe = 1'b0;
         ST_DATA_LO: if (rnw_q) sda_oe = 1'b0; else sda_out = wr_q[{1'b0, ~bit_q}];
         ST_ACK_LO:  if (!rnw_q) sda_oe = 1'b0;
         ST_STOP:    sda_out = (phase >= STOP_SDA_PHASE);
         default:    sda_oe = 1'b0;
      endcase
   end

   assign SDA_OUT = sda_out;
   assign SDA_OE  = sda_oe;
   assign BUSY    = busy;
   assign DONE    = done_q;
   assign NACK    = nack_q;
   assign RD_DATA = rd_q;

endmodule

// File: tb/tb_i2c_primary_ctrl.sv
// Bench: protocol-level secondary model decodes the bus, results checked
// against transaction-level expectations (frames, latency, bytes, NACK).
module tb_i2c_primary_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        START_STB = 1'b0;
   logic        RNW = 1'b0;
   logic [6:0]  I2C_ADDR = '0;
   logic [15:0] WR_DATA = '0;
   logic [15:0] RD_DATA;
   logic        BUSY, DONE, NACK, SCL, SDA_OUT, SDA_OE;
   logic        sda_in = 1'b1;

   i2c_primary_ctrl #(.PHASES(4)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START_STB (START_STB),
      .RNW       (RNW),
      .I2C_ADDR  (I2C_ADDR),
      .WR_DATA   (WR_DATA),
      .RD_DATA   (RD_DATA),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .NACK      (NACK),
      .SCL       (SCL),
      .SDA_OUT   (SDA_OUT),
      .SDA_OE    (SDA_OE),
      .SDA_IN    (sda_in)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Secondary model configuration and observations.
   logic [6:0]  sec_addr = '0;
   logic        sec_ack_hi = 1'b1, sec_ack_lo = 1'b1;
   logic [15:0] sec_rd = '0;
   logic        p_scl = 1'b1, p_line = 1'b1;
   logic        addr_acked = 1'b0;
   logic [7:0]  shreg = '0;
   logic [7:0]  rx_byte [0:3];
   logic        rx_ack  [0:3];
   int          nrise = 0, starts = 0, stops = 0;

   always @(negedge CLK) begin : secondary
      logic scl, line;
      int   f, pos;
      if (!RESET) sda_in = 1'b1;
      scl  = SCL;
      line = SDA_OUT & sda_in;
      // SDA may only move under high SCL as START or STOP; anything else shows up as extra events.
      if (p_scl && scl && p_line && !line) begin
         starts++;
         nrise      = 0;
         addr_acked = 1'b0;
      end
      if (p_scl && scl && !p_line && line) stops++;
      if (!p_scl && scl) begin
         f = nrise / 9; pos = nrise % 9;
         if (f < 4) begin
            if (pos < 8) shreg = {shreg[6:0], line};
            if (pos == 7) rx_byte[f] = shreg;
            if (pos == 8) rx_ack[f] = line;
         end
         nrise++;
      end
      if (p_scl && !scl) begin
         f = nrise / 9; pos = nrise % 9;
         sda_in = 1'b1;
         if (f == 0 && pos == 8 && rx_byte[0][7:1] == sec_addr) begin
            sda_in     = 1'b0;
            addr_acked = 1'b1;
         end else if ((f == 1 || f == 2) && addr_acked) begin
            if (rx_byte[0][0] && pos < 8)
               sda_in = sec_rd[(f == 1 ? 15 : 7) - pos];
            else if (!rx_byte[0][0] && pos == 8)
               sda_in = (f == 1) ? !sec_ack_hi : !sec_ack_lo;
         end
      end
      p_scl  = scl;
      p_line = SDA_OUT & sda_in;
   end

   logic [15:0] rd_model = '0;

   task automatic xfer(input logic rnw, input logic [6:0] addr, input logic [15:0] wd,
                       input logic [6:0] saddr, input logic ahi, input logic alo,
                       input logic [15:0] srd, input bit mid_stb);
      int          n, frames, exp_lat;
      logic        exp_nack;
      sec_addr = saddr; sec_ack_hi = ahi; sec_ack_lo = alo; sec_rd = srd;
      starts = 0; stops = 0;
      frames   = (saddr != addr) ? 1 : (!rnw && !ahi) ? 2 : 3;
      exp_nack = (frames < 3);
      exp_lat  = 4 * (2 + 9 * frames);
      if (frames == 3 && rnw) rd_model = srd;
      RNW = rnw; I2C_ADDR = addr; WR_DATA = wd; START_STB = 1'b1;
      @(negedge CLK);
      START_STB = 1'b0;
      chk("busy_start", BUSY, 1'b1);
      chk("nack_clr", NACK, 1'b0);
      n = 0;
      while (!DONE && n < 300) begin
         if (mid_stb && n == 50) begin
            START_STB = 1'b1; WR_DATA = ~wd; I2C_ADDR = ~addr; RNW = ~rnw;
         end else begin
            START_STB = 1'b0;
         end
         @(negedge CLK);
         n++;
      end
      START_STB = 1'b0;
      chk("latency", n, exp_lat);
      chk("busy_at_done", BUSY, 1'b0);
      chk("nack", NACK, exp_nack);
      chk("rd_data", RD_DATA, rd_model);
      chk("addr_byte", rx_byte[0], {addr, rnw});
      if (!rnw && frames >= 2) chk("wr_hi", rx_byte[1], wd[15:8]);
      if (!rnw && frames == 3) chk("wr_lo", rx_byte[2], wd[7:0]);
      if (rnw && frames == 3) begin
         chk("prim_ack_hi", rx_ack[1], 1'b0);
         chk("prim_nack_lo", rx_ack[2], 1'b1);
      end
      chk("starts", starts, 1);
      chk("stops", stops, 1);
      @(negedge CLK);
      chk("done_pulse", DONE, 1'b0);
      chk("idle_sda_oe", SDA_OE, 1'b0);
   endtask

   initial begin
      logic        r, ahi, alo;
      logic [6:0]  a, sa;
      logic        done_seen;
      repeat (3) @(negedge CLK);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_nack", NACK, 1'b0);
      chk("rst_rd", RD_DATA, 16'h0);
      chk("rst_scl", SCL, 1'b1);
      chk("rst_sda", SDA_OUT, 1'b1);
      chk("rst_oe", SDA_OE, 1'b0);
      RESET = 1'b1;
      @(negedge CLK);

      xfer(1'b0, 7'h2A, 16'hBEEF, 7'h2A, 1'b1, 1'b1, 16'h0, 1'b0);
      xfer(1'b1, 7'h11, 16'h0,    7'h11, 1'b1, 1'b1, 16'h1234, 1'b0);
      xfer(1'b0, 7'h33, 16'h5555, 7'h00, 1'b1, 1'b1, 16'h0, 1'b0);
      xfer(1'b0, 7'h2A, 16'h5A3C, 7'h2A, 1'b1, 1'b1, 16'h0, 1'b1);
      xfer(1'b0, 7'h40, 16'hC001, 7'h40, 1'b0, 1'b1, 16'h0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         r   = 1'($urandom_range(0, 1));
         a   = 7'($urandom);
         sa  = ($urandom_range(0, 3) == 0) ? (a ^ 7'h01) : a;
         ahi = ($urandom_range(0, 4) != 0);
         alo = 1'($urandom_range(0, 1));
         xfer(r, a, 16'($urandom), sa, ahi, alo, 16'($urandom), 1'($urandom_range(0, 1)));
      end

      // Reset in DATA_HI bit 3 of a write.
      sec_addr = 7'h2A; sec_ack_hi = 1'b1; starts = 0; stops = 0;
      RNW = 1'b0; I2C_ADDR = 7'h2A; WR_DATA = 16'hA5C3; START_STB = 1'b1;
      @(negedge CLK);
      START_STB = 1'b0;
      repeat (53) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      rd_model = '0;
      chk("mid_rst_busy", BUSY, 1'b0);
      chk("mid_rst_done", DONE, 1'b0);
      chk("mid_rst_scl", SCL, 1'b1);
      chk("mid_rst_sda", SDA_OUT, 1'b1);
      chk("mid_rst_oe", SDA_OE, 1'b0);
      chk("mid_rst_rd", RD_DATA, 16'h0);
      chk("mid_rst_nack", NACK, 1'b0);
      done_seen = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         if (DONE || BUSY) done_seen = 1'b1;
      end
      chk("mid_rst_quiet", done_seen, 1'b0);
      chk("mid_rst_nostop", stops, 0);

      // START_STB during reset is discarded.
      RESET = 1'b0; START_STB = 1'b1;
      @(negedge CLK);
      RESET = 1'b1; START_STB = 1'b0;
      chk("stb_in_rst", BUSY, 1'b0);
      @(negedge CLK);
      chk("stb_in_rst2", BUSY, 1'b0);

      xfer(1'b1, 7'h11, 16'h0, 7'h11, 1'b1, 1'b1, 16'h8E71, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
